// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between the I-cache miss port and the D-cache port.
// Optional ARB_ROUND_ROBIN_EN selects round-robin contention handling instead of D-over-I priority.
module cache_mem_arbiter #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               i_strobe,
  input  logic [A_WIDTH-1:0] i_a,
  output logic               i_ready,
  output logic [D_WIDTH-1:0] i_dout,
  input  logic               d_strobe,
  input  logic               d_wr,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [D_WIDTH-1:0] d_wdata,
  output logic               d_ready,
  output logic [D_WIDTH-1:0] d_dout,
  output logic               m_strobe,
  output logic               m_wr,
  output logic [A_WIDTH-1:0] m_a,
  output logic [D_WIDTH-1:0] m_wdata,
  input  logic               m_ready,
  input  logic [D_WIDTH-1:0] m_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D was granted last, 0 = I was granted last
  logic last_grant;

  always_comb begin
    grant_d = d_strobe;
    if (i_strobe && d_strobe) grant_d = ~last_grant;
  end
`else
  always_comb begin
    grant_d = d_strobe;
  end
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      m_wr    <= 1'b0;
      m_a     <= '0;
      m_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_strobe || d_strobe) begin
            if (grant_d) begin
              m_a     <= d_a;
              m_wdata <= d_wdata;
              m_wr    <= d_wr;
              state   <= GNT_D;
            end else begin
              m_a   <= i_a;
              m_wr  <= 1'b0;
              state <= GNT_I;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_d;
`endif
          end
        end
        GNT_I, GNT_D: begin
          if (m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is reported in the same cycle as m_ready; the IDLE state masks stray m_ready
  always_comb begin
    m_strobe = (state == GNT_I) || (state == GNT_D);
    busy     = m_strobe;
    i_ready  = (state == GNT_I) && m_ready;
    d_ready  = (state == GNT_D) && m_ready;
    i_dout   = m_rdata;
    d_dout   = m_rdata;
  end

endmodule
